gcn_fetch_unit: RTL and testbench

- Read-initiator side of the GCN memory interface. It drives read_address and enable_read and captures data_in.
- Loads all weight columns into a local buffer, then streams feature rows one at a time to the FM×WM compute stage over a valid/ready handshake.
- Sits inside the GCN top, between the external combinational memory port and the dot-product array.

---
 rtl/gcn_pkg.sv | 20 ++
 rtl/gcn_fetch_addr_gen.sv | 71 +++++++
 rtl/gcn_fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_gcn_fetch_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcn_pkg.sv
// Shared GCN types and widths: fetch FSM encoding, memory map base and datapath widths.
package gcn_pkg;

    localparam int unsigned FEATURE_WIDTH  = 5;
    localparam int unsigned WEIGHT_WIDTH   = 5;
    localparam int unsigned ADDRESS_WIDTH  = 13;
    // Product width plus growth for a 96-term accumulation.
    localparam int unsigned DOT_PROD_WIDTH = FEATURE_WIDTH + WEIGHT_WIDTH + 7;

    localparam logic [ADDRESS_WIDTH-1:0] FEATURE_BASE = 13'h200;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StLoadF,
        StWaitRdy,
        StDone
    } fetch_state_t;

endpackage

// File: rtl/gcn_fetch_addr_gen.sv
// Weight-column / feature-row counters and the read-address mux for the fetch unit.
module gcn_fetch_addr_gen
    import gcn_pkg::*;
#(
    parameter int unsigned WeightCols  = 3,
    parameter int unsigned FeatureRows = 6,
    parameter int unsigned AddrW       = 13,
    parameter int unsigned RowIdxW     = 3,
    parameter int unsigned ColIdxW     = (WeightCols > 1) ? $clog2(WeightCols) : 1,
    parameter logic [AddrW-1:0] FeatureBase = AddrW'(FEATURE_BASE)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               c_clr_i,
    input  logic               c_inc_i,
    input  logic               r_clr_i,
    input  logic               r_inc_i,
    input  logic               sel_w_i,
    input  logic               sel_f_i,
    output logic [ColIdxW-1:0] col_idx_o,
    output logic [RowIdxW-1:0] row_idx_o,
    output logic [AddrW-1:0]   addr_o,
    output logic               last_w_o,
    output logic               last_f_o
);

    logic [ColIdxW-1:0] c_q, c_d;
    logic [RowIdxW-1:0] r_q, r_d;

    assign last_w_o = (c_q == ColIdxW'(WeightCols - 1));
    assign last_f_o = (r_q == RowIdxW'(FeatureRows - 1));

    // Increments are gated by the last flags so neither counter can wrap.
    always_comb begin
        c_d = c_q;
        r_d = r_q;
        if (c_clr_i) begin
            c_d = '0;
        end else if (c_inc_i && !last_w_o) begin
            c_d = c_q + ColIdxW'(1);
        end
        if (r_clr_i || c_clr_i) begin
            r_d = '0;
        end else if (r_inc_i && !last_f_o) begin
            r_d = r_q + RowIdxW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            c_q <= '0;
            r_q <= '0;
        end else begin
            c_q <= c_d;
            r_q <= r_d;
        end
    end

    always_comb begin
        addr_o = '0;
        if (sel_w_i) begin
            addr_o = AddrW'(c_q);
        end else if (sel_f_i) begin
            addr_o = FeatureBase + AddrW'(r_q);
        end
    end

    assign col_idx_o = c_q;
    assign row_idx_o = r_q;

endmodule

// File: rtl/gcn_fetch_unit.sv
// GCN fetch unit: loads all weight columns, then streams feature rows over valid/ready.
module gcn_fetch_unit #(
    parameter int unsigned FEATURE_ROWS  = 6,
    parameter int unsigned FEATURE_COLS  = 96,
    parameter int unsigned WEIGHT_ROWS   = 96,
    parameter int unsigned WEIGHT_COLS   = 3,
    parameter int unsigned FEATURE_WIDTH = gcn_pkg::FEATURE_WIDTH,
    parameter int unsigned WEIGHT_WIDTH  = gcn_pkg::WEIGHT_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = gcn_pkg::ADDRESS_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0] FEATURE_BASE = ADDRESS_WIDTH'(gcn_pkg::FEATURE_BASE),
    parameter int unsigned ROW_IDX_W     = $clog2(FEATURE_ROWS)
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  start,
    input  logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0]              data_in,
    output logic [ADDRESS_WIDTH-1:0]                              read_address,
    output logic                                                  enable_read,
    output logic [WEIGHT_COLS-1:0][WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] weight_buf,
    output logic                                                  weights_valid,
    output logic [FEATURE_COLS-1:0][FEATURE_WIDTH-1:0]            feature_row,
    output logic [ROW_IDX_W-1:0]                                  feature_idx,
    output logic                                                  feature_valid,
    input  logic                                                  feature_ready,
    output logic                                                  fetch_done
);

    import gcn_pkg::*;

    localparam int unsigned ColIdxW = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;

    fetch_state_t state_q, state_d;

    logic                 weights_valid_q, weights_valid_d;
    logic                 feature_valid_q, feature_valid_d;
    logic                 fetch_done_q, fetch_done_d;
    logic [ROW_IDX_W-1:0] feature_idx_q, feature_idx_d;

    logic [WEIGHT_COLS-1:0][WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] weight_q;
    logic [FEATURE_COLS-1:0][FEATURE_WIDTH-1:0]                feature_row_q;

    logic                 c_clr, c_inc, r_clr, r_inc;
    logic                 load_w, load_f;
    logic                 last_w, last_f;
    logic                 sel_w, sel_f;
    logic [ColIdxW-1:0]   col_idx;
    logic [ROW_IDX_W-1:0] row_idx;

    assign sel_w = (state_q == StLoadW);
    // Address holds the last feature row through WAIT_RDY and DONE.
    assign sel_f = (state_q == StLoadF) || (state_q == StWaitRdy) || (state_q == StDone);

    gcn_fetch_addr_gen #(
        .WeightCols  (WEIGHT_COLS),
        .FeatureRows (FEATURE_ROWS),
        .AddrW       (ADDRESS_WIDTH),
        .RowIdxW     (ROW_IDX_W),
        .ColIdxW     (ColIdxW),
        .FeatureBase (FEATURE_BASE)
    ) u_addr_gen (
        .clk_i     (clk),
        .rst_i     (reset),
        .c_clr_i   (c_clr),
        .c_inc_i   (c_inc),
        .r_clr_i   (r_clr),
        .r_inc_i   (r_inc),
        .sel_w_i   (sel_w),
        .sel_f_i   (sel_f),
        .col_idx_o (col_idx),
        .row_idx_o (row_idx),
        .addr_o    (read_address),
        .last_w_o  (last_w),
        .last_f_o  (last_f)
    );

    always_comb begin
        state_d         = state_q;
        weights_valid_d = weights_valid_q;
        feature_valid_d = feature_valid_q;
        fetch_done_d    = fetch_done_q;
        feature_idx_d   = feature_idx_q;
        enable_read     = 1'b0;
        c_clr           = 1'b0;
        c_inc           = 1'b0;
        r_clr           = 1'b0;
        r_inc           = 1'b0;
        load_w          = 1'b0;
        load_f          = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    c_clr   = 1'b1;
                    state_d = StLoadW;
                end
            end
            StLoadW: begin
                enable_read = 1'b1;
                load_w      = 1'b1;
                if (last_w) begin
                    weights_valid_d = 1'b1;
                    r_clr           = 1'b1;
                    state_d         = StLoadF;
                end else begin
                    c_inc = 1'b1;
                end
            end
            StLoadF: begin
                enable_read     = 1'b1;
                load_f          = 1'b1;
                feature_idx_d   = row_idx;
                feature_valid_d = 1'b1;
                state_d         = StWaitRdy;
            end
            StWaitRdy: begin
                if (feature_valid_q && feature_ready) begin
                    feature_valid_d = 1'b0;
                    if (last_f) begin
                        fetch_done_d = 1'b1;
                        state_d      = StDone;
                    end else begin
                        r_inc   = 1'b1;
                        state_d = StLoadF;
                    end
                end
            end
            StDone: begin
                // No auto-restart: start must drop before a new run.
                if (!start) begin
                    fetch_done_d    = 1'b0;
                    weights_valid_d = 1'b0;
                    state_d         = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            weights_valid_q <= 1'b0;
            feature_valid_q <= 1'b0;
            fetch_done_q    <= 1'b0;
            feature_idx_q   <= '0;
        end else begin
            state_q         <= state_d;
            weights_valid_q <= weights_valid_d;
            feature_valid_q <= feature_valid_d;
            fetch_done_q    <= fetch_done_d;
            feature_idx_q   <= feature_idx_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weight_q      <= '0;
            feature_row_q <= '0;
        end else begin
            if (load_w) begin
                weight_q[col_idx] <= data_in;
            end
            if (load_f) begin
                // Memory words are WEIGHT_WIDTH wide; the cast truncates or zero-extends.
                for (int k = 0; k < FEATURE_COLS; k++) begin
                    feature_row_q[k] <= FEATURE_WIDTH'(data_in[k]);
                end
            end
        end
    end

    assign weight_buf    = weight_q;
    assign weights_valid = weights_valid_q;
    assign feature_row   = feature_row_q;
    assign feature_idx   = feature_idx_q;
    assign feature_valid = feature_valid_q;
    assign fetch_done    = fetch_done_q;

endmodule

// File: tb/tb_gcn_fetch_unit.sv
// Scoreboard bench for gcn_fetch_unit with a behavioural memory and reference queues.
module tb_gcn_fetch_unit;

    localparam int FR = 6;
    localparam int FC = 96;
    localparam int WR = 96;
    localparam int WC = 3;
    localparam int FW = 5;
    localparam int WW = 5;
    localparam int AW = 13;
    localparam int FBASE = 'h200;

    logic                          clk = 1'b0;
    logic                          reset;
    logic                          start;
    logic [WR-1:0][WW-1:0]         data_in;
    logic [AW-1:0]                 read_address;
    logic                          enable_read;
    logic [WC-1:0][WR-1:0][WW-1:0] weight_buf;
    logic                          weights_valid;
    logic [FC-1:0][FW-1:0]         feature_row;
    logic [2:0]                    feature_idx;
    logic                          feature_valid;
    logic                          feature_ready;
    logic                          fetch_done;

    gcn_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .data_in       (data_in),
        .read_address  (read_address),
        .enable_read   (enable_read),
        .weight_buf    (weight_buf),
        .weights_valid (weights_valid),
        .feature_row   (feature_row),
        .feature_idx   (feature_idx),
        .feature_valid (feature_valid),
        .feature_ready (feature_ready),
        .fetch_done    (fetch_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void check(string name, logic [479:0] act, logic [479:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Memory contents: weight column c at address c, feature row r at FBASE+r.
    logic [WW-1:0] wmem [WC][WR];
    logic [WW-1:0] fmem [FR][WR];

    always_comb begin
        data_in = '0;
        if (enable_read) begin
            if (int'(read_address) < WC) begin
                for (int k = 0; k < WR; k++) data_in[k] = wmem[int'(read_address)][k];
            end else if (int'(read_address) >= FBASE && int'(read_address) < FBASE + FR) begin
                for (int k = 0; k < WR; k++) data_in[k] = fmem[int'(read_address) - FBASE][k];
            end
        end
    end

    task automatic fill_formula();
        for (int c = 0; c < WC; c++) for (int k = 0; k < WR; k++) wmem[c][k] = WW'((c + k) % 32);
        for (int r = 0; r < FR; r++) for (int k = 0; k < WR; k++) fmem[r][k] = WW'((r * 3 + k) % 32);
    endtask

    task automatic fill_random();
        for (int c = 0; c < WC; c++) for (int k = 0; k < WR; k++) wmem[c][k] = WW'($urandom);
        for (int r = 0; r < FR; r++) for (int k = 0; k < WR; k++) fmem[r][k] = WW'($urandom);
    endtask

    // Reference expectations for one full run.
    typedef struct {
        int           idx;
        logic [479:0] row;
    } row_t;

    int           addr_q[$];
    row_t         row_q[$];
    logic [479:0] wexp_q[$];
    int           reads = 0;

    task automatic push_run();
        row_t         e;
        logic [479:0] v;
        for (int c = 0; c < WC; c++) addr_q.push_back(c);
        for (int r = 0; r < FR; r++) addr_q.push_back(FBASE + r);
        for (int r = 0; r < FR; r++) begin
            v = '0;
            for (int k = 0; k < FC; k++) v[k*FW +: FW] = FW'(fmem[r][k] % (1 << FW));
            e.idx = r;
            e.row = v;
            row_q.push_back(e);
        end
        for (int c = 0; c < WC; c++) begin
            v = '0;
            for (int k = 0; k < WR; k++) v[k*WW +: WW] = wmem[c][k];
            wexp_q.push_back(v);
        end
    endtask

    task automatic flush();
        addr_q.delete();
        row_q.delete();
        wexp_q.delete();
    endtask

    // Monitor: samples on the falling edge, pops and compares.
    logic wv_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            wv_prev = 1'b0;
        end else begin
            if (enable_read) begin
                reads++;
                if (addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_read: got addr %0h expected no read", read_address);
                end else begin
                    check("read_addr", read_address, addr_q.pop_front());
                end
            end
            if (feature_valid && feature_ready) begin
                if (row_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_row: got idx %0d expected none", feature_idx);
                end else begin
                    row_t e;
                    e = row_q.pop_front();
                    check("row_idx", feature_idx, e.idx);
                    check("row_data", feature_row, e.row);
                end
            end
            if (weights_valid && !wv_prev) begin
                for (int c = 0; c < WC; c++) begin
                    if (wexp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL weight_col: got col %0d expected no weights", c);
                    end else begin
                        check("weight_col", weight_buf[c], wexp_q.pop_front());
                    end
                end
            end
            wv_prev = weights_valid;
        end
    end

    // 0: ready low, 1: ready high, 2: random, 3: driven by the main sequence
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) feature_ready = 1'b0;
        else if (ready_mode == 1) feature_ready = 1'b1;
        else if (ready_mode == 2) feature_ready = 1'($urandom_range(0, 1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!fetch_done && n < 500) begin
            step();
            n++;
        end
        check(name, fetch_done, 1);
        check({name, "_addr_q_empty"}, addr_q.size(), 0);
        check({name, "_row_q_empty"}, row_q.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_enable_read"}, enable_read, 0);
        check({tag, "_read_address"}, read_address, 0);
        check({tag, "_weights_valid"}, weights_valid, 0);
        check({tag, "_feature_valid"}, feature_valid, 0);
        check({tag, "_feature_idx"}, feature_idx, 0);
        check({tag, "_fetch_done"}, fetch_done, 0);
        check({tag, "_weight_buf_zero"}, (weight_buf == '0), 1);
        check({tag, "_feature_row_zero"}, (feature_row == '0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int first_fv;
        int done_at;
        bit saw4;

        reset = 1'b1;
        start = 1'b0;
        feature_ready = 1'b0;
        fill_formula();
        step();
        step();
        check_zero_outputs("reset");
        reset = 1'b0;
        step();

        // Run 1: formula memory, ready high everywhere including IDLE/LOAD_W.
        push_run();
        reads = 0;
        ready_mode = 1;
        step();
        start = 1'b1;
        n = 0;
        first_fv = -1;
        done_at = -1;
        saw4 = 0;
        while (done_at < 0 && n < 200) begin
            step();
            n++;
            if (feature_valid && first_fv < 0) first_fv = n;
            if (feature_valid && feature_idx == 3'd4 && !saw4) begin
                saw4 = 1;
                check("row4_elem0", feature_row[0], 12);
            end
            if (fetch_done) done_at = n;
        end
        check("first_valid_latency", first_fv, 5);
        check("done_latency", done_at, 16);
        check("row4_seen", saw4, 1);
        check("weight_2_95", weight_buf[2][95], 1);
        check("weight_0_31", weight_buf[0][31], 31);
        check("read_count", reads, 9);

        // Start held high: stay in DONE with no reads.
        repeat (8) step();
        check("hold_done", fetch_done, 1);
        check("hold_weights_valid", weights_valid, 1);
        check("hold_read_count", reads, 9);
        start = 1'b0;
        step();
        check("idle_fetch_done", fetch_done, 0);
        check("idle_weights_valid", weights_valid, 0);
        check("idle_enable_read", enable_read, 0);

        // Run 2: stall on row 2 for 7 cycles.
        fill_random();
        push_run();
        ready_mode = 3;
        feature_ready = 1'b0;
        start = 1'b1;
        n = 0;
        while (!(feature_valid && feature_idx == 3'd2) && n < 200) begin
            step();
            n++;
            if (!(feature_valid && feature_idx == 3'd2)) feature_ready = feature_valid;
        end
        feature_ready = 1'b0;
        check("stall_reached", feature_valid, 1);
        for (int i = 0; i < 7; i++) begin
            step();
            check("stall_valid", feature_valid, 1);
            check("stall_idx", feature_idx, 2);
            check("stall_no_read", enable_read, 0);
        end
        feature_ready = 1'b1;
        step();
        feature_ready = 1'b0;
        check("resume_enable_read", enable_read, 1);
        check("resume_addr", read_address, 'h203);
        ready_mode = 2;
        wait_done("run2_done");
        start = 1'b0;
        step();

        // Run 3: abort with reset during LOAD_F of row 3.
        fill_random();
        push_run();
        ready_mode = 1;
        start = 1'b1;
        n = 0;
        while (!(enable_read && read_address == AW'(FBASE + 3)) && n < 200) begin
            step();
            n++;
        end
        check("abort_point_reached", read_address, FBASE + 3);
        reset = 1'b1;
        start = 1'b0;
        #1;
        check_zero_outputs("abort");
        flush();
        step();
        step();
        reset = 1'b0;
        step();
        fill_random();
        push_run();
        start = 1'b1;
        step();
        check("restart_addr", read_address, 0);
        check("restart_enable_read", enable_read, 1);
        check("restart_wv_1", weights_valid, 0);
        step();
        step();
        check("restart_wv_3", weights_valid, 0);
        step();
        check("restart_wv_4", weights_valid, 1);
        ready_mode = 2;
        wait_done("run3_done");
        start = 1'b0;
        step();

        // Randomized runs.
        for (int run = 0; run < 3; run++) begin
            fill_random();
            push_run();
            ready_mode = 2;
            repeat ($urandom_range(1, 4)) step();
            start = 1'b1;
            wait_done("rand_done");
            repeat ($urandom_range(0, 3)) step();
            check("rand_hold_done", fetch_done, 1);
            start = 1'b0;
            step();
            check("rand_idle", fetch_done, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
